// File: rtl/kv_mem_arbiter.sv
// rtl/kv_mem_arbiter.sv - single-port memory arbiter for I-fetch, D-fetch and D write-back
// One transaction in flight; write-back has priority, fetches alternate round-robin.
module kv_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 4,
  localparam int LINE_WIDTH = DATA_WIDTH * LINE_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [ADDR_WIDTH-1:0] i_ifetch_addr,
  input  logic                  i_ifetch_valid,
  output logic                  o_ifetch_ready,
  output logic [LINE_WIDTH-1:0] o_ifetch_data,
  output logic                  o_ifetch_rvalid,
  input  logic                  i_ifetch_rready,
  input  logic [ADDR_WIDTH-1:0] i_dfetch_addr,
  input  logic                  i_dfetch_valid,
  output logic                  o_dfetch_ready,
  output logic [LINE_WIDTH-1:0] o_dfetch_data,
  output logic                  o_dfetch_rvalid,
  input  logic                  i_dfetch_rready,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [LINE_WIDTH-1:0] i_wb_data,
  input  logic                  i_wb_valid,
  output logic                  o_wb_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [LINE_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  input  logic [LINE_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_rvalid,
  output logic                  o_mem_rready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_last_d;   // 1: D-fetch was granted last, so I-fetch wins the next tie
  logic                  r_sel_d;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_buf;
  logic                  w_gnt_wb;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic                  w_rready_sel;

  assign w_rready_sel = r_sel_d ? i_dfetch_rready : i_ifetch_rready;

  always_comb begin
    w_next   = r_state;
    w_gnt_wb = 1'b0;
    w_gnt_i  = 1'b0;
    w_gnt_d  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Grants are suppressed while reset is asserted so every ready reads 0 then.
        if (i_rstn) begin
          if (i_wb_valid) begin
            w_gnt_wb = 1'b1;
          end else if (i_ifetch_valid && i_dfetch_valid) begin
            w_gnt_i = r_last_d;
            w_gnt_d = !r_last_d;
          end else begin
            w_gnt_i = i_ifetch_valid;
            w_gnt_d = i_dfetch_valid;
          end
        end
        if (w_gnt_wb || w_gnt_i || w_gnt_d) w_next = S_REQ;
      end
      S_REQ: begin
        if (i_mem_ready) w_next = r_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_rvalid) w_next = S_DELIVER;
      end
      S_DELIVER: begin
        if (w_rready_sel) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b1;
      r_sel_d  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buf    <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_wb || w_gnt_i || w_gnt_d) begin
        r_we    <= w_gnt_wb;
        r_sel_d <= w_gnt_d;
        r_addr  <= w_gnt_wb ? i_wb_addr : (w_gnt_i ? i_ifetch_addr : i_dfetch_addr);
        if (w_gnt_wb) r_wdata <= i_wb_data;
      end
      if (w_gnt_i) r_last_d <= 1'b0;
      if (w_gnt_d) r_last_d <= 1'b1;
      if (r_state == S_WAIT && i_mem_rvalid) r_buf <= i_mem_rdata;
    end
  end

  assign o_wb_ready      = w_gnt_wb;
  assign o_ifetch_ready  = w_gnt_i;
  assign o_dfetch_ready  = w_gnt_d;
  assign o_mem_valid     = (r_state == S_REQ);
  assign o_mem_we        = (r_state == S_REQ) && r_we;
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;
  assign o_mem_rready    = (r_state == S_WAIT);
  assign o_ifetch_rvalid = (r_state == S_DELIVER) && !r_sel_d;
  assign o_dfetch_rvalid = (r_state == S_DELIVER) && r_sel_d;
  assign o_ifetch_data   = r_buf;
  assign o_dfetch_data   = r_buf;

endmodule
